// File: rtl/riscv_fetch_queue_pkg.sv
//------------------------------------------------------------------------------
// Module   : riscv_fetch_queue_pkg
// Purpose  : Shared constants and types for the RV32 instruction-fetch queue.
//            INSN_WIDTH : instruction word width
//            PC_STEP    : PC increment between sequential fetches
//            INSN_NOP   : canonical NOP (addi x0,x0,0) shown on an empty queue
//            fetch_state_e : fetch FSM states
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_fetch_queue_pkg;

  localparam int          INSN_WIDTH = 32;
  localparam int          PC_STEP    = 4;
  localparam logic [31:0] INSN_NOP   = 32'h0000_0013;

  // RUN     : normal streaming fetch
  // DISCARD : waiting out a bus request that a redirect made stale
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } fetch_state_e;

endpackage : riscv_fetch_queue_pkg

`default_nettype wire

// File: rtl/riscv_sync_fifo.sv
//------------------------------------------------------------------------------
// Module   : riscv_sync_fifo
// Purpose  : Synchronous circular-buffer FIFO with wrapping pointers, occupancy
//            count and a single-cycle flush. Storage is registered, so a pushed
//            entry becomes visible at the head one cycle after the push.
// Ports    : clock        in   clock, all state on rising edge
//            reset        in   synchronous active-high reset
//            flush_i      in   empty the FIFO (wins over push/pop)
//            push_i       in   write push_data_i at the tail
//            push_data_i  in   [WIDTH-1:0] entry to write
//            pop_i        in   drop the head entry (no-op when empty)
//            head_data_o  out  [WIDTH-1:0] current head entry
//            count_o      out  occupied entries, 0..DEPTH
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riscv_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_eff;
  logic             push_eff;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when the head is leaving in the same cycle.
  assign pop_eff  = pop_i && (count_q != '0);
  assign push_eff = push_i && ((count_q != C_FULL) || pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy tracking guards its use.
  always_ff @(posedge clock) begin
    if (!flush_i && push_eff) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule : riscv_sync_fifo

`default_nettype wire

// File: rtl/riscv_fetch_queue.sv
//------------------------------------------------------------------------------
// Module   : riscv_fetch_queue
// Purpose  : RV32 instruction-fetch front end. Owns the program counter,
//            drives the instruction bus and buffers up to DEPTH fetched
//            instructions with their PCs so fetch keeps streaming while the
//            downstream stage stalls. Redirects flush the queue.
// Ports    : clock               in   clock
//            reset               in   synchronous active-high reset
//            instruction_address out  fetch address (stable while pending)
//            instruction_read    out  fetch request
//            instruction_data    in   fetched word, valid with ready
//            instruction_ready   in   request completes this cycle
//            redirect            in   flush and restart fetch at redirect_pc
//            redirect_pc         in   new target, bits [1:0] ignored
//            out_valid           out  head entry present
//            out_pc              out  PC of head entry
//            out_instruction     out  head instruction, NOP when empty
//            out_accept          in   consumer pops the head this cycle
//            count               out  occupied entries
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riscv_fetch_queue
  import riscv_fetch_queue_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [ADDR_WIDTH-1:0]        instruction_address,
  output logic                         instruction_read,
  input  logic [INSN_WIDTH-1:0]        instruction_data,
  input  logic                         instruction_ready,
  input  logic                         redirect,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         out_valid,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [INSN_WIDTH-1:0]        out_instruction,
  input  logic                         out_accept,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_WIDTH + INSN_WIDTH;
  localparam logic [CNT_W-1:0]      C_FULL = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_STEP = ADDR_WIDTH'(PC_STEP);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] target_pc_q, target_pc_d;

  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  bus_done;
  logic                  bus_pending;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Full is judged on the registered count only, so out_accept never reaches
  // instruction_read combinationally. Once raised, read cannot drop before
  // ready: count can only fall until this request's own push. In DISCARD the
  // stale request is kept alive until the bus completes it.
  always_comb begin
    instruction_read = 1'b0;
    if (!reset) begin
      instruction_read = (state_q == ST_DISCARD) || (fifo_count != C_FULL);
    end
  end

  assign instruction_address = fetch_pc_q;
  assign bus_done            = instruction_read && instruction_ready;
  assign bus_pending         = instruction_read && !instruction_ready;

  // Redirect overrides both handshakes: its cycle neither pushes nor pops.
  assign fifo_push = (state_q == ST_RUN) && bus_done && !redirect;
  assign fifo_pop  = out_valid && out_accept && !redirect;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    target_pc_d = target_pc_q;
    if (redirect) begin
      target_pc_d = redirect_target;
      if (state_q == ST_DISCARD) begin
        // Stale request still outstanding; retarget, and if it completes now
        // resume directly at the newest target.
        if (instruction_ready) begin
          fetch_pc_d = redirect_target;
          state_d    = ST_RUN;
        end
      end else if (bus_pending) begin
        state_d = ST_DISCARD;
      end else begin
        fetch_pc_d = redirect_target;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (fifo_push) fetch_pc_d = fetch_pc_q + C_STEP;
        end
        ST_DISCARD: begin
          if (instruction_ready) begin
            fetch_pc_d = target_pc_q;
            state_d    = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      fetch_pc_q  <= RESET_PC;
      target_pc_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      target_pc_q <= target_pc_d;
    end
  end

  riscv_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (redirect),
    .push_i      (fifo_push),
    .push_data_i ({fetch_pc_q, instruction_data}),
    .pop_i       (fifo_pop),
    .head_data_o (fifo_head),
    .count_o     (fifo_count)
  );

  assign out_valid       = !reset && (fifo_count != '0);
  assign out_pc          = fifo_head[ENTRY_W-1:INSN_WIDTH];
  assign out_instruction = out_valid ? fifo_head[INSN_WIDTH-1:0] : INSN_NOP;
  assign count           = fifo_count;

endmodule : riscv_fetch_queue

`default_nettype wire

// File: tb/tb_riscv_fetch_queue.sv
//------------------------------------------------------------------------------
// Module   : tb_riscv_fetch_queue
// Purpose  : Self-checking bench for riscv_fetch_queue (DEPTH=4,
//            RESET_PC=0x100). A queue-based reference model predicts every
//            output each cycle; directed sequences add literal expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_riscv_fetch_queue;

  localparam int          AW   = 32;
  localparam int          DEP  = 4;
  localparam logic [31:0] RPC  = 32'h100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction_address;
  logic        instruction_read;
  logic [31:0] instruction_data;
  logic        instruction_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        out_accept;
  logic [2:0]  count;

  riscv_fetch_queue #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEP),
    .RESET_PC   (RPC)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .instruction_address (instruction_address),
    .instruction_read    (instruction_read),
    .instruction_data    (instruction_data),
    .instruction_ready   (instruction_ready),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .out_valid           (out_valid),
    .out_pc              (out_pc),
    .out_instruction     (out_instruction),
    .out_accept          (out_accept),
    .count               (count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a list of {pc, insn} entries, the next fetch address,
  // and whether a stale bus request is being waited out.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic        m_disc;
  logic [31:0] m_tgt;
  logic        e_read;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then compare every
  // output with the model's prediction.
  task automatic setin(input logic rst, input logic rdy, input logic rdr,
                       input logic [31:0] rpc, input logic acc);
    @(negedge clock);
    reset             = rst;
    instruction_ready = rdy;
    redirect          = rdr;
    redirect_pc       = rpc;
    out_accept        = acc;
    instruction_data  = $urandom;
    #1;
    e_read = !rst && (m_disc || (mq.size() < DEP));
    chk("read", 64'(instruction_read), 64'(e_read));
    if (e_read) chk("address", 64'(instruction_address), 64'(m_pc));
    chk("count", 64'(count), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(!rst && (mq.size() != 0)));
    if (!rst && mq.size() != 0) begin
      chk("out_pc", 64'(out_pc), 64'(mq[0][63:32]));
      chk("out_insn", 64'(out_instruction), 64'(mq[0][31:0]));
    end else begin
      chk("out_insn_nop", 64'(out_instruction), 64'(NOP));
    end
  endtask

  // Advance the model across the rising edge using the applied inputs.
  task automatic tick();
    logic [31:0] tgt;
    @(posedge clock);
    tgt = {redirect_pc[31:2], 2'b00};
    if (reset) begin
      mq.delete();
      m_pc   = RPC;
      m_disc = 1'b0;
    end else if (redirect) begin
      mq.delete();
      if (m_disc) begin
        m_tgt = tgt;
        if (instruction_ready) begin
          m_pc   = tgt;
          m_disc = 1'b0;
        end
      end else if (e_read && !instruction_ready) begin
        m_disc = 1'b1;
        m_tgt  = tgt;
      end else begin
        m_pc = tgt;
      end
    end else if (m_disc) begin
      if (instruction_ready) begin
        m_pc   = m_tgt;
        m_disc = 1'b0;
      end
    end else begin
      if (out_accept && mq.size() != 0) void'(mq.pop_front());
      if (e_read && instruction_ready) begin
        mq.push_back({m_pc, instruction_data});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_read", 64'(instruction_read), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    tick();
  endtask

  initial begin
    reset = 1'b1; instruction_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; out_accept = 1'b0; instruction_data = '0;
    m_pc = RPC; m_disc = 1'b0; m_tgt = RPC; e_read = 1'b0;

    // 1: streaming with ready and accept always high
    do_reset();
    setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("s1_addr0", 64'(instruction_address), 64'h100);
    chk("s1_read0", 64'(instruction_read), 64'd1);
    chk("s1_cnt0", 64'(count), 64'd0);
    tick();
    setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("s1_addr1", 64'(instruction_address), 64'h104);
    chk("s1_opc1", 64'(out_pc), 64'h100);
    tick();
    for (int i = 0; i < 4; i++) begin setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); tick(); end

    // 2: fill with no consumer, then a single pop
    do_reset();
    for (int i = 0; i < 4; i++) begin setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick(); end
    setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("s2_full_cnt", 64'(count), 64'd4);
    chk("s2_full_read", 64'(instruction_read), 64'd0);
    tick();
    setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("s2_cnt3", 64'(count), 64'd3);
    chk("s2_read", 64'(instruction_read), 64'd1);
    chk("s2_addr", 64'(instruction_address), 64'h110);
    tick();

    // 3: ready delayed three cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      setin(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("s3_hold_addr", 64'(instruction_address), 64'h100);
      tick();
    end
    setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    setin(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("s3_cnt", 64'(count), 64'd1);
    chk("s3_addr", 64'(instruction_address), 64'h104);

    // 4: redirect while the request at 0x104 is pending
    setin(1'b0, 1'b0, 1'b1, 32'h203, 1'b0);
    tick();
    setin(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("s4_hold_addr", 64'(instruction_address), 64'h104);
    chk("s4_cnt", 64'(count), 64'd0);
    tick();
    setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    setin(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("s4_new_addr", 64'(instruction_address), 64'h200);
    chk("s4_dropped", 64'(count), 64'd0);
    tick();

    // 5: redirect + accept + ready together at count 2
    do_reset();
    for (int i = 0; i < 2; i++) begin setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick(); end
    setin(1'b0, 1'b1, 1'b1, 32'h300, 1'b1);
    chk("s5_cnt2", 64'(count), 64'd2);
    tick();
    setin(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("s5_cnt0", 64'(count), 64'd0);
    chk("s5_addr", 64'(instruction_address), 64'h300);
    tick();

    // 6: reset while in DISCARD
    do_reset();
    for (int i = 0; i < 3; i++) begin setin(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick(); end
    setin(1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
    chk("s6_cnt3", 64'(count), 64'd3);
    tick();
    do_reset();
    setin(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("s6_cnt", 64'(count), 64'd0);
    chk("s6_addr", 64'(instruction_address), 64'h100);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      setin(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 15) == 0),
            $urandom,
            ($urandom_range(0, 9) < 5));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule : tb_riscv_fetch_queue

`default_nettype wire
